// File: rtl/if_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// if_fetch_stage_pkg
// Shared state encoding, constants and PC helper for the MIPS fetch stage.
// Revision: 1.0
// ============================================================================
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SKID    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// if_fetch_stage_if
// Instruction-memory req/ready bus between the fetch stage and imem.
// Revision: 1.0
// ============================================================================
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_skid_buffer.sv
`default_nettype none
// ============================================================================
// if_skid_buffer
// One-entry {instruction, pc_plus4} holding register with load, clear, full.
// Revision: 1.0
// ============================================================================
module if_skid_buffer (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_load,
    input  wire logic        i_clear,
    input  wire logic [31:0] i_instr,
    input  wire logic [31:0] i_pc4,
    output logic [31:0]      o_instr,
    output logic [31:0]      o_pc4,
    output logic             o_full
);

    logic        r_full_q;
    logic [31:0] r_instr_q;
    logic [31:0] r_pc4_q;
    logic        w_full_d;
    logic [31:0] w_instr_d;
    logic [31:0] w_pc4_d;

    always_comb begin
        w_full_d  = r_full_q;
        w_instr_d = r_instr_q;
        w_pc4_d   = r_pc4_q;
        if (i_clear) begin
            w_full_d = 1'b0;
        end else if (i_load) begin
            w_full_d  = 1'b1;
            w_instr_d = i_instr;
            w_pc4_d   = i_pc4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full_q  <= 1'b0;
            r_instr_q <= 32'h0000_0000;
            r_pc4_q   <= 32'h0000_0000;
        end else begin
            r_full_q  <= w_full_d;
            r_instr_q <= w_instr_d;
            r_pc4_q   <= w_pc4_d;
        end
    end

    assign o_instr = r_instr_q;
    assign o_pc4   = r_pc4_q;
    assign o_full  = r_full_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// if_fetch_stage
// MIPS IF stage: PC, imem req/ready fetch, IF/ID register, skid and redirect.
// Optional IF_FETCH_COUNT_EN adds fetch_count / stall_count outputs.
// Revision: 1.0
// ============================================================================
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall,
    input  wire logic        branch_taken,
    input  wire logic [31:0] branch_target,
    if_fetch_stage_if.master imem,
    output logic [31:0]      instruction,
    output logic [31:0]      pc_plus4,
`ifdef IF_FETCH_COUNT_EN
    output logic [31:0]      fetch_count,
    output logic [31:0]      stall_count,
`endif
    output logic             valid
);

    fetch_state_e r_state_q, w_state_d;
    logic [31:0]  r_pc_q,    w_pc_d;
    logic [31:0]  r_addr_q,  w_addr_d;
    logic         r_req_q,   w_req_d;
    logic [31:0]  r_instr_q, w_instr_d;
    logic [31:0]  r_pc4_q,   w_pc4_d;
    logic         r_valid_q, w_valid_d;

    logic         w_accept;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_target;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc4;
    logic         w_skid_full;

    assign w_accept  = r_req_q & imem.imem_ready;
    assign w_pc_next = r_pc_q + PC_STEP;
    assign w_target  = align_pc(branch_target);

    if_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem.imem_rdata),
        .i_pc4   (w_pc_next),
        .o_instr (w_skid_instr),
        .o_pc4   (w_skid_pc4),
        .o_full  (w_skid_full)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_addr_d     = r_addr_q;
        w_instr_d    = r_instr_q;
        w_pc4_d      = r_pc4_q;
        w_valid_d    = r_valid_q;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;

        // A redirect always bubbles IF/ID unless decode is stalled.
        if (branch_taken && !stall) begin
            w_instr_d = NOP_INSTR;
            w_pc4_d   = 32'h0000_0000;
            w_valid_d = 1'b0;
        end

        unique case (r_state_q)
            FETCH: begin
                if (branch_taken) begin
                    w_skid_clear = 1'b1;
                    w_pc_d       = w_target;
                    if (w_accept) begin
                        w_addr_d  = w_target;
                        w_state_d = FETCH;
                    end else begin
                        w_state_d = DISCARD;
                    end
                end else if (w_accept) begin
                    w_pc_d   = w_pc_next;
                    w_addr_d = w_pc_next;
                    if (!stall) begin
                        w_instr_d = imem.imem_rdata;
                        w_pc4_d   = w_pc_next;
                        w_valid_d = 1'b1;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_d   = SKID;
                    end
                end else if (!stall) begin
                    w_instr_d = NOP_INSTR;
                    w_pc4_d   = 32'h0000_0000;
                    w_valid_d = 1'b0;
                end
            end

            SKID: begin
                if (branch_taken) begin
                    w_skid_clear = 1'b1;
                    w_pc_d       = w_target;
                    w_addr_d     = w_target;
                    w_state_d    = FETCH;
                end else if (!stall && w_skid_full) begin
                    w_instr_d    = w_skid_instr;
                    w_pc4_d      = w_skid_pc4;
                    w_valid_d    = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_d    = FETCH;
                end
            end

            DISCARD: begin
                if (!stall) begin
                    w_instr_d = NOP_INSTR;
                    w_pc4_d   = 32'h0000_0000;
                    w_valid_d = 1'b0;
                end
                // The stored target lives in r_pc_q; a new branch overwrites it.
                if (branch_taken) begin
                    w_pc_d = w_target;
                end
                if (w_accept) begin
                    w_addr_d  = branch_taken ? w_target : r_pc_q;
                    w_state_d = FETCH;
                end
            end

            default: begin
                w_state_d = FETCH;
                w_pc_d    = RESET_PC;
                w_addr_d  = RESET_PC;
            end
        endcase

        w_req_d = (w_state_d != SKID);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= FETCH;
            r_pc_q    <= RESET_PC;
            r_addr_q  <= RESET_PC;
            r_req_q   <= 1'b0;
            r_instr_q <= NOP_INSTR;
            r_pc4_q   <= 32'h0000_0000;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_addr_q  <= w_addr_d;
            r_req_q   <= w_req_d;
            r_instr_q <= w_instr_d;
            r_pc4_q   <= w_pc4_d;
            r_valid_q <= w_valid_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] r_fetch_cnt_q, w_fetch_cnt_d;
    logic [31:0] r_stall_cnt_q, w_stall_cnt_d;

    // With stall low IF/ID is always rewritten, so a valid write is simply valid_d.
    always_comb begin
        w_fetch_cnt_d = r_fetch_cnt_q + {31'd0, (~stall & w_valid_d)};
        w_stall_cnt_d = r_stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt_q <= 32'h0000_0000;
            r_stall_cnt_q <= 32'h0000_0000;
        end else begin
            r_fetch_cnt_q <= w_fetch_cnt_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign fetch_count = r_fetch_cnt_q;
    assign stall_count = r_stall_cnt_q;
`endif

    assign imem.imem_req  = r_req_q;
    assign imem.imem_addr = r_addr_q;
    assign instruction    = r_instr_q;
    assign pc_plus4       = r_pc4_q;
    assign valid          = r_valid_q;

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the MIPS pipeline, directly upstream of the ID register file. Owns the program counter, issues word fetches to instruction memory over a req/ready handshake, and drives the IF/ID pipeline register (instruction, PC+4, valid) that the decode stage reads. Supports hazard stalls through a one-entry skid buffer, and branch redirects with discard of in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from decode; holds the IF/ID register.
- branch_taken  in  1  one-cycle redirect pulse from decode.
- branch_target  in  32  redirect address; bits [1:0] forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC.
- imem_ready  in  1  memory accept; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched word.
- instruction  out  32  IF/ID instruction, feeding decode `instruction[31:0]`.
- pc_plus4  out  32  IF/ID PC+4 of that instruction.
- valid  out  1  IF/ID entry holds a real instruction; 0 means bubble (instruction = 0, a NOP).

## Operation
- The FSM has three states: FETCH, SKID and DISCARD. Reset enters FETCH with pc = RESET_PC.
- FETCH: imem_req = 1.
  - Accept when imem_req & imem_ready. On accept, pc <= pc + 4.
  - On accept with stall = 0: IF/ID <= {imem_rdata, pc + 4, valid = 1}.
  - On accept with stall = 1: the word goes to the skid buffer and the FSM moves to SKID.
  - No accept and stall = 0: IF/ID <= bubble.
- SKID: imem_req = 0. IF/ID holds while stall = 1. When stall = 0, the skid word moves into IF/ID and the FSM returns to FETCH.
- Handshake rule: once imem_req is asserted, imem_addr stays stable until the accept.
- branch_taken has priority over stall:
  - IF/ID <= bubble, unless stall = 1, in which case IF/ID holds.
  - The skid word is dropped.
  - pc <= {branch_target[31:2], 2'b00}.
  - In FETCH with no accept that cycle, the FSM moves to DISCARD.
  - In FETCH with an accept, the word is dropped and the FSM goes to FETCH at the target.
- DISCARD: imem_req stays 1 on the old address. The accepted word is dropped, then the FSM enters FETCH at the stored target. A second branch_taken in DISCARD overwrites the stored target.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values: pc = RESET_PC, instruction = 0, pc_plus4 = 0, valid = 0, state FETCH. imem_req goes to 1 on the first cycle after reset deasserts.
- Reset mid-fetch clears all state immediately; the outstanding request is abandoned.
- Latency: a word accepted at edge N is on instruction/valid after edge N (one register stage).
- Zero-wait memory (imem_ready held at 1) sustains one instruction per cycle.
- While stall = 1, IF/ID outputs are bit-for-bit stable.
- The first target word can be accepted no earlier than the cycle after branch_taken.

## Configuration
- IF_FETCH_COUNT_EN:
  - Defined: adds outputs fetch_count (32) and stall_count (32), both reset to 0. fetch_count increments once per word written to IF/ID with valid = 1. stall_count increments on every cycle with stall = 1. Both wrap modulo 2^32.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- A shared package holds:
  - the state enum (FETCH, SKID, DISCARD);
  - NOP_INSTR = 32'h0000_0000;
  - PC_STEP = 4.
- One sub-module, if_skid_buffer: a one-entry {instruction, pc_plus4} holding register with load, clear and full.

## Test plan
- Reset with RESET_PC = 32'h0040_0000 and imem_ready held at 1 -> imem_addr reads 0040_0000, 0040_0004, ... and valid rises one cycle after the first accept.
- imem_ready low for 3 cycles -> imem_addr stable throughout, valid = 0 for 3 cycles, no PC change.
- stall held 2 cycles while a word 32'h2008_0005 is accepted -> IF/ID unchanged during the stall, imem_req = 0, then 2008_0005 appears with the correct pc_plus4.
- branch_taken to 32'h0040_0103 while a request is pending -> pending word dropped, next imem_addr = 0040_0100, IF/ID bubble.
- branch_taken and stall in the same cycle with the skid full -> IF/ID held, skid dropped, fetch resumes at the target.
- Under IF_FETCH_COUNT_EN, 10 instructions with 4 stall cycles -> fetch_count = 10, stall_count = 4.
